trace_capture_sequencer: RTL and testbench

//  Sequences capture of the 4-bit TRACEDATA stream into a circular trace buffer.

---
 rtl/trace_capture_sequencer.sv | 130 +++++++++++++
 tb/tb_trace_capture_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_sequencer.sv
// Trace capture sequencer: pre-trigger fill, trigger wait, post-trigger fill into a circular buffer.
// Every output is registered. A sample seen on trace_data at cycle n is written at cycle n+1.
module trace_capture_sequencer #(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    ADDR_WIDTH = 15,
    parameter logic [DATA_WIDTH-1:0] IDLE_A     = 4'h7,
    parameter logic [DATA_WIDTH-1:0] IDLE_B     = 4'hf
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [1:0]            trig_mode,
    input  logic [DATA_WIDTH-1:0] match_value,
    input  logic [DATA_WIDTH-1:0] match_mask,
    input  logic [ADDR_WIDTH-1:0] pre_samples,
    input  logic [ADDR_WIDTH-1:0] post_samples,
    input  logic                  ext_trig,
    input  logic [DATA_WIDTH-1:0] trace_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  trig_out,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t                state, state_d;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] value_q, mask_q;
    logic [ADDR_WIDTH-1:0] pre_q, post_q, cnt, waddr;
    logic                  arm_go, hit, do_write, do_trig, cnt_clr;

    assign arm_go = arm && !abort && (state == S_IDLE || state == S_DONE);

    always_comb begin
        case (mode_q)
            2'd0:    hit = ext_trig;
            2'd1:    hit = ((trace_data ^ value_q) & mask_q) == '0;
            2'd2:    hit = (trace_data != IDLE_A) && (trace_data != IDLE_B);
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state;
        do_write = 1'b0;
        do_trig  = 1'b0;
        cnt_clr  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                // Live port value: the latched copy is not valid until after this edge.
                if (arm) state_d = (pre_samples == '0) ? S_WAIT : S_PRE;
            end
            S_PRE: begin
                do_write = 1'b1;
                if (cnt == pre_q - ADDR_WIDTH'(1)) begin
                    state_d = S_WAIT;
                    cnt_clr = 1'b1;
                end
            end
            S_WAIT: begin
                do_write = 1'b1;
                if (hit) begin
                    do_trig = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = (post_q == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                do_write = 1'b1;
                if (cnt == post_q - ADDR_WIDTH'(1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            do_write = 1'b0;
            do_trig  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            value_q   <= '0;
            mask_q    <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            cnt       <= '0;
            waddr     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            trig_out  <= 1'b0;
            trig_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_d;
            wr_en    <= do_write;
            trig_out <= do_trig;
            if (arm_go) begin
                mode_q  <= trig_mode;
                value_q <= match_value;
                mask_q  <= match_mask;
                pre_q   <= pre_samples;
                post_q  <= post_samples;
                cnt     <= '0;
                waddr   <= '0;
            end else begin
                if (cnt_clr)       cnt <= '0;
                else if (do_write) cnt <= cnt + ADDR_WIDTH'(1);
                if (do_write)      waddr <= waddr + ADDR_WIDTH'(1);
            end
            if (do_write) begin
                wr_addr <= waddr;
                wr_data <= trace_data;
            end
            if (do_trig) trig_addr <= waddr;
            // busy covers the final write's output cycle; done follows it directly.
            busy <= (state_d == S_PRE || state_d == S_WAIT || state_d == S_POST) ||
                    (state_d == S_DONE && state != S_DONE && state != S_IDLE);
            done <= (state == S_DONE) && (state_d == S_DONE);
        end
    end
endmodule

// File: tb/tb_trace_capture_sequencer.sv
// Directed bench for trace_capture_sequencer: a 15-bit instance plus a 4-bit
// address instance for the buffer-wrap scenario, both fed the same stimulus.
module tb_trace_capture_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm = 1'b0, abort = 1'b0, ext_trig = 1'b0;
    logic [1:0]  trig_mode = '0;
    logic [3:0]  match_value = '0, match_mask = '0, trace_data = '0;
    logic [14:0] pre_samples = '0, post_samples = '0;

    logic        wr_en, trig_out, busy, done;
    logic [14:0] wr_addr, trig_addr;
    logic [3:0]  wr_data;
    logic        wr_en4, trig_out4, busy4, done4;
    logic [3:0]  wr_addr4, trig_addr4, wr_data4;

    int errors = 0;
    int checks = 0;

    trace_capture_sequencer dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .match_value(match_value), .match_mask(match_mask),
        .pre_samples(pre_samples), .post_samples(post_samples), .ext_trig(ext_trig),
        .trace_data(trace_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .trig_out(trig_out), .trig_addr(trig_addr), .busy(busy), .done(done)
    );

    trace_capture_sequencer #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .match_value(match_value), .match_mask(match_mask),
        .pre_samples(pre_samples[3:0]), .post_samples(post_samples[3:0]), .ext_trig(ext_trig),
        .trace_data(trace_data), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .trig_out(trig_out4), .trig_addr(trig_addr4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] d, input logic e);
        trace_data = d;
        ext_trig   = e;
        tick();
    endtask

    task automatic start(input logic [1:0] m, input logic [3:0] v, input logic [3:0] k,
                         input int pre, input int post);
        trig_mode    = m;
        match_value  = v;
        match_mask   = k;
        pre_samples  = 15'(pre);
        post_samples = 15'(post);
        abort = 1'b1; tick(); abort = 1'b0;
        arm   = 1'b1; tick(); arm   = 1'b0;
    endtask

    task automatic test_reset();
        arm = 1'b1;
        for (int i = 0; i < 6; i++) begin
            trace_data = 4'(i * 5);
            tick();
            checks++;
            if ({wr_en, trig_out, busy, done} !== 4'b0 || wr_addr !== '0 || wr_data !== '0 ||
                trig_addr !== '0) begin
                errors++;
                $display("FAIL reset cyc%0d: en=%b tr=%b busy=%b done=%b addr=%0d data=%h taddr=%0d, want all 0",
                         i, wr_en, trig_out, busy, done, wr_addr, wr_data, trig_addr);
            end
        end
        arm = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_pattern();
        start(2'd1, 4'hA, 4'hF, 4, 3);
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL pattern_armed: busy=%b wr_en=%b, want busy=1 wr_en=0", busy, wr_en);
        end
        for (int i = 0; i < 4; i++) begin
            feed(4'h7, 1'b0);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 15'(i) || wr_data !== 4'h7 || trig_out !== 1'b0) begin
                errors++;
                $display("FAIL pattern_pre%0d: en=%b addr=%0d data=%h tr=%b, want 1 %0d 7 0",
                         i, wr_en, wr_addr, wr_data, trig_out, i);
            end
        end
        feed(4'hA, 1'b0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 15'd4 || trig_out !== 1'b1 || trig_addr !== 15'd4) begin
            errors++;
            $display("FAIL pattern_trig: en=%b addr=%0d tr=%b taddr=%0d, want 1 4 1 4",
                     wr_en, wr_addr, trig_out, trig_addr);
        end
        for (int i = 0; i < 3; i++) begin
            feed(4'(i + 1), 1'b0);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 15'(5 + i) || trig_out !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL pattern_post%0d: en=%b addr=%0d tr=%b done=%b, want 1 %0d 0 0",
                         i, wr_en, wr_addr, trig_out, done, 5 + i);
            end
        end
        feed(4'hA, 1'b0);
        checks++;
        if (wr_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || trig_addr !== 15'd4) begin
            errors++;
            $display("FAIL pattern_done: en=%b done=%b busy=%b taddr=%0d, want 0 1 0 4",
                     wr_en, done, busy, trig_addr);
        end
    endtask

    task automatic test_nonidle();
        logic [3:0] s [4];
        s = '{4'h7, 4'hF, 4'hF, 4'h3};
        start(2'd2, 4'h0, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            feed(s[i], 1'b0);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 15'(i) || wr_data !== s[i] ||
                trig_out !== (i == 3) || done !== 1'b0) begin
                errors++;
                $display("FAIL nonidle%0d: en=%b addr=%0d data=%h tr=%b done=%b, want 1 %0d %h %0d 0",
                         i, wr_en, wr_addr, wr_data, trig_out, done, i, s[i], i == 3);
            end
        end
        feed(4'h3, 1'b0);
        checks++;
        if (wr_en !== 1'b0 || done !== 1'b1 || trig_addr !== 15'd3 || trig_out !== 1'b0) begin
            errors++;
            $display("FAIL nonidle_done: en=%b done=%b taddr=%0d tr=%b, want 0 1 3 0",
                     wr_en, done, trig_addr, trig_out);
        end
    endtask

    task automatic test_pre_blocks();
        start(2'd1, 4'hA, 4'hF, 2, 1);
        for (int i = 0; i < 3; i++) begin
            feed(4'hA, 1'b0);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 15'(i) || trig_out !== (i == 2)) begin
                errors++;
                $display("FAIL preblock%0d: en=%b addr=%0d tr=%b, want 1 %0d %0d",
                         i, wr_en, wr_addr, trig_out, i, i == 2);
            end
        end
        checks++;
        if (trig_addr !== 15'd2) begin
            errors++;
            $display("FAIL preblock_taddr: got %0d want 2", trig_addr);
        end
        feed(4'h1, 1'b0);
        feed(4'h1, 1'b0);
        checks++;
        if (done !== 1'b1 || wr_addr !== 15'd3) begin
            errors++;
            $display("FAIL preblock_done: done=%b last_addr=%0d, want 1 3", done, wr_addr);
        end
    endtask

    task automatic test_wrap();
        start(2'd0, 4'h0, 4'h0, 14, 2);
        for (int i = 0; i < 23; i++) begin
            feed(4'(i), i == 20);
            checks++;
            if (wr_en4 !== 1'b1 || wr_addr4 !== 4'(i % 16) || trig_out4 !== (i == 20)) begin
                errors++;
                $display("FAIL wrap%0d: en=%b addr=%0d tr=%b, want 1 %0d %0d",
                         i, wr_en4, wr_addr4, trig_out4, i % 16, i == 20);
            end
        end
        feed(4'h0, 1'b0);
        checks++;
        if (trig_addr4 !== 4'd4 || wr_addr4 !== 4'd6 || done4 !== 1'b1 || wr_en4 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: taddr=%0d last=%0d done=%b en=%b, want 4 6 1 0",
                     trig_addr4, wr_addr4, done4, wr_en4);
        end
        checks++;
        if (trig_addr !== 15'd20) begin
            errors++;
            $display("FAIL wide_taddr: got %0d want 20", trig_addr);
        end
    endtask

    task automatic test_abort();
        start(2'd0, 4'h0, 4'h0, 1, 2);
        feed(4'h5, 1'b0);
        feed(4'h6, 1'b0);
        trace_data = 4'h2; ext_trig = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; ext_trig = 1'b0;
        checks++;
        if (trig_out !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort: tr=%b en=%b busy=%b done=%b, want 0 0 0 0",
                     trig_out, wr_en, busy, done);
        end
        checks++;
        if (trig_addr !== 15'd20) begin
            errors++;
            $display("FAIL abort_hold_taddr: got %0d want 20", trig_addr);
        end
        arm = 1'b1; tick(); arm = 1'b0;
        feed(4'h9, 1'b0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 15'd0 || wr_data !== 4'h9) begin
            errors++;
            $display("FAIL rearm: en=%b addr=%0d data=%h, want 1 0 9", wr_en, wr_addr, wr_data);
        end
        arm = 1'b1;
        feed(4'h3, 1'b0);
        arm = 1'b0;
        feed(4'h4, 1'b0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 15'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arm_ignored: en=%b addr=%0d busy=%b, want 1 2 1", wr_en, wr_addr, busy);
        end
    endtask

    task automatic test_async_reset();
        start(2'd2, 4'h0, 4'h0, 5, 5);
        feed(4'h1, 1'b0);
        feed(4'h2, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || wr_addr !== '0 || trig_addr !== '0) begin
            errors++;
            $display("FAIL async_reset: en=%b busy=%b addr=%0d taddr=%0d, want 0 0 0 0",
                     wr_en, busy, wr_addr, trig_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_nonidle();
        test_pre_blocks();
        test_wrap();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
